bbox_iterator: RTL and testbench

Rasterizer stage directly upstream of the per-sample edge test. Accepts one triangle per handshake with its snapped bounding box, then walks the box in raster order at the configured sub-sample pitch. Emits one candidate sample per cycle, with the triangle and color held alongside. Back-pressures the triangle setup stage through `halt_RnnnnL` while a box is being walked.

---
 rtl/bbox_iterator.sv | 159 +++++++++++++++
 tb/tb_bbox_iterator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_iterator.sv
// rtl/bbox_iterator.sv - bounding-box sample walker feeding the per-sample edge test
// Purpose: latch one triangle with its snapped bounding box and emit every
// sample position of the box in raster order, one per cycle, with the
// triangle and color held alongside.
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   tri_R15S, color_R15U   incoming triangle vertices and color
//   box_R15S               [0] = lower-left (x, y), [1] = upper-right (x, y)
//   validTri_R15H          incoming triangle/box valid
//   subSample_RnnnnU       one-hot sample pitch (1000 = one sample per pixel)
//   halt_RnnnnL            low while a box is being walked; upstream holds
//   tri_R16S, color_R16U   triangle and color of the samples being emitted
//   sample_R16S            current sample (x, y)
//   validSamp_R16H         sample valid
//   sampCount_R16U         running count of emitted samples (ITER_COUNT_EN only)
// Optional feature macro: ITER_COUNT_EN
module bbox_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R15S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R15U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R15S [2][2],
  input  logic                     validTri_R15H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R16U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R16S [2],
  output logic                     validSamp_R16H
`ifdef ITER_COUNT_EN
  ,
  output logic        [31:0]       sampCount_R16U
`endif
);

  // One extra bit so that ur + step can never wrap during the compares.
  localparam int CW = SIGFIG + 1;
  typedef logic signed [CW-1:0] coord_t;
  typedef enum logic {WAIT, TEST} state_t;

  state_t state_q, state_d;
  coord_t ll_x_q, ur_x_q, ur_y_q;
  coord_t step;
  coord_t in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  coord_t cur_x, cur_y, nx, nxt_x, nxt_y;
  logic   in_empty, in_last, nxt_last;
  logic   load, valid_d;
  logic signed [SIGFIG-1:0] samp_x_d, samp_y_d;

  function automatic coord_t ext(input logic signed [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v};
  endfunction

  always_comb begin
    case (subSample_RnnnnU)
      4'b0100: step = coord_t'(1) << (RADIX - 1);
      4'b0010: step = coord_t'(1) << (RADIX - 2);
      4'b0001: step = coord_t'(1) << (RADIX - 3);
      default: step = coord_t'(1) << RADIX;
    endcase
  end

  // Incoming box: emptiness and whether ll is already the only sample.
  assign in_ll_x  = ext(box_R15S[0][0]);
  assign in_ll_y  = ext(box_R15S[0][1]);
  assign in_ur_x  = ext(box_R15S[1][0]);
  assign in_ur_y  = ext(box_R15S[1][1]);
  assign in_empty = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
  assign in_last  = (in_ll_x + step > in_ur_x) && (in_ll_y + step > in_ur_y);

  // Successor of the registered sample, plus a look-ahead on whether that
  // successor is the final one, so the FSM leaves TEST on the same edge that
  // registers the last sample (zero bubble to the next triangle).
  assign cur_x = ext(sample_R16S[0]);
  assign cur_y = ext(sample_R16S[1]);

  always_comb begin
    nx = cur_x + step;
    if (nx <= ur_x_q) begin
      nxt_x = nx;
      nxt_y = cur_y;
    end else begin
      nxt_x = ll_x_q;
      nxt_y = cur_y + step;
    end
  end

  assign nxt_last = (nxt_x + step > ur_x_q) && (nxt_y + step > ur_y_q);

  assign halt_RnnnnL = (state_q == WAIT);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    valid_d  = 1'b0;
    samp_x_d = sample_R16S[0];
    samp_y_d = sample_R16S[1];
    case (state_q)
      WAIT: begin
        if (validTri_R15H) begin
          load     = 1'b1;
          samp_x_d = box_R15S[0][0];
          samp_y_d = box_R15S[0][1];
          valid_d  = !in_empty;
          if (!in_empty && !in_last) state_d = TEST;
        end
      end
      TEST: begin
        samp_x_d = nxt_x[SIGFIG-1:0];
        samp_y_d = nxt_y[SIGFIG-1:0];
        valid_d  = 1'b1;
        if (nxt_last) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= WAIT;
      validSamp_R16H <= 1'b0;
      sample_R16S    <= '{default: '0};
      tri_R16S       <= '{default: '0};
      color_R16U     <= '{default: '0};
      ll_x_q         <= '0;
      ur_x_q         <= '0;
      ur_y_q         <= '0;
    end else begin
      state_q        <= state_d;
      validSamp_R16H <= valid_d;
      sample_R16S[0] <= samp_x_d;
      sample_R16S[1] <= samp_y_d;
      if (load) begin
        tri_R16S   <= tri_R15S;
        color_R16U <= color_R15U;
        ll_x_q     <= in_ll_x;
        ur_x_q     <= in_ur_x;
        ur_y_q     <= in_ur_y;
      end
    end
  end

`ifdef ITER_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampCount_R16U <= '0;
    end else if (valid_d) begin
      sampCount_R16U <= sampCount_R16U + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bbox_iterator.sv
// tb/tb_bbox_iterator.sv - self-checking bench for bbox_iterator
module tb_bbox_iterator;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R15S [3][3];
  logic        [SIGFIG-1:0] color_R15U [3];
  logic signed [SIGFIG-1:0] box_R15S [2][2];
  logic                     validTri_R15H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R16S [3][3];
  logic        [SIGFIG-1:0] color_R16U [3];
  logic signed [SIGFIG-1:0] sample_R16S [2];
  logic                     validSamp_R16H;
`ifdef ITER_COUNT_EN
  logic        [31:0]       sampCount_R16U;
`endif

  int checks = 0;
  int errors = 0;
  int qx[$];
  int qy[$];
  logic signed [SIGFIG-1:0] exp_tri [3][3];
  logic        [SIGFIG-1:0] exp_color [3];
  int          exp_sx, exp_sy;
  logic [31:0] exp_count;
  bit          accepted;

  always #5 clk = ~clk;

  bbox_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R15S         (tri_R15S),
    .color_R15U       (color_R15U),
    .box_R15S         (box_R15S),
    .validTri_R15H    (validTri_R15H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R16S         (tri_R16S),
    .color_R16U       (color_R16U),
    .sample_R16S      (sample_R16S),
    .validSamp_R16H   (validSamp_R16H)
`ifdef ITER_COUNT_EN
    ,
    .sampCount_R16U   (sampCount_R16U)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample pitch in grid units from the one-hot encoding.
  function automatic int pitch_step(input logic [3:0] p);
    if (p == 4'b0100) return 2 ** (RADIX - 1);
    if (p == 4'b0010) return 2 ** (RADIX - 2);
    if (p == 4'b0001) return 2 ** (RADIX - 3);
    return 2 ** RADIX;
  endfunction

  task automatic model_reset();
    qx.delete();
    qy.delete();
    exp_sx = 0;
    exp_sy = 0;
    exp_count = '0;
    for (int v = 0; v < 3; v++) begin
      exp_color[v] = '0;
      for (int a = 0; a < 3; a++) exp_tri[v][a] = '0;
    end
  endtask

  task automatic check_latched();
    for (int v = 0; v < 3; v++) begin
      chk($sformatf("color[%0d]", v), color_R16U[v], exp_color[v]);
      for (int a = 0; a < 3; a++)
        chk($sformatf("tri[%0d][%0d]", v, a), tri_R16S[v][a], exp_tri[v][a]);
    end
  endtask

  // One clock: an accept happens on this edge if a triangle is offered while
  // the DUT is not halting upstream. An accepted box expands into its full
  // raster-order sample list; each output cycle shows the head of that list.
  task automatic cycle();
    bit acc;
    bit exp_valid;
    acc = validTri_R15H && halt_RnnnnL;
    @(posedge clk);
    #1;
    accepted = acc;
    if (acc) begin
      int s, llx, lly, urx, ury;
      s   = pitch_step(subSample_RnnnnU);
      llx = box_R15S[0][0];
      lly = box_R15S[0][1];
      urx = box_R15S[1][0];
      ury = box_R15S[1][1];
      exp_tri   = tri_R15S;
      exp_color = color_R15U;
      exp_sx = llx;
      exp_sy = lly;
      for (int y = lly; y <= ury; y += s)
        for (int x = llx; x <= urx; x += s) begin
          qx.push_back(x);
          qy.push_back(y);
        end
    end
    exp_valid = (qx.size() > 0);
    if (exp_valid) begin
      exp_sx = qx.pop_front();
      exp_sy = qy.pop_front();
      exp_count++;
    end
    chk("validSamp", validSamp_R16H, exp_valid);
    chk("halt", halt_RnnnnL, qx.size() == 0);
    chk("sample_x", sample_R16S[0], exp_sx);
    chk("sample_y", sample_R16S[1], exp_sy);
    check_latched();
`ifdef ITER_COUNT_EN
    chk("sampCount", sampCount_R16U, exp_count);
`endif
  endtask

  task automatic present(input int llx, input int lly, input int urx, input int ury, output int ncyc);
    for (int v = 0; v < 3; v++) begin
      color_R15U[v] = SIGFIG'($urandom);
      for (int a = 0; a < 3; a++) tri_R15S[v][a] = SIGFIG'($urandom);
    end
    box_R15S[0][0] = SIGFIG'(llx);
    box_R15S[0][1] = SIGFIG'(lly);
    box_R15S[1][0] = SIGFIG'(urx);
    box_R15S[1][1] = SIGFIG'(ury);
    validTri_R15H = 1'b1;
    ncyc = 0;
    do begin
      cycle();
      ncyc++;
    end while (!accepted && ncyc < 500);
    chk("accept_timeout", accepted, 1);
  endtask

  task automatic idle(input int n);
    validTri_R15H = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    validTri_R15H = 1'b0;
    do begin
      cycle();
      budget++;
    end while (qx.size() > 0 && budget < 5000);
    chk("drain_timeout", qx.size() == 0, 1);
  endtask

  initial begin
    int n;
    logic [3:0] pitches [8];
    pitches = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0110, 4'b1111, 4'b1000};

    rst = 1'b0;
    validTri_R15H = 1'b0;
    subSample_RnnnnU = 4'b1000;
    box_R15S = '{default: '0};
    tri_R15S = '{default: '0};
    color_R15U = '{default: '0};
    model_reset();
    #2;
    chk("rst_halt", halt_RnnnnL, 1);
    chk("rst_valid", validSamp_R16H, 0);
    chk("rst_sample_x", sample_R16S[0], 0);
    chk("rst_sample_y", sample_R16S[1], 0);
    check_latched();
`ifdef ITER_COUNT_EN
    chk("rst_sampCount", sampCount_R16U, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // 2x2 at one sample per pixel, then a single-sample box.
    present(0, 0, 1024, 1024, n);
    drain();
    present(2048, 512, 2048, 512, n);
    drain();
`ifdef ITER_COUNT_EN
    chk("count_after_two_boxes", sampCount_R16U, 5);
`endif

    // Back-to-back: B offered while A is still being walked.
    present(0, 0, 1024, 1024, n);
    present(4096, 2048, 5120, 2048, n);
    drain();

    // Finer pitch, then an unsupported encoding on the same box.
    subSample_RnnnnU = 4'b0100;
    present(0, 0, 512, 512, n);
    drain();
    subSample_RnnnnU = 4'b0110;
    present(0, 0, 512, 512, n);
    drain();

    // Box at the top of the positive range: ur + step must not wrap.
    subSample_RnnnnU = 4'b1000;
    present(8386560, -1024, 8387584, 0, n);
    drain();

    // Empty box is consumed on the first edge with no valid samples.
    present(1024, 0, 0, 0, n);
    chk("empty_accept_cycles", n, 1);
    drain();

    // Reset in the middle of a 3x3 walk.
    present(0, 0, 2048, 2048, n);
    idle(2);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_valid", validSamp_R16H, 0);
    chk("midrst_halt", halt_RnnnnL, 1);
    chk("midrst_sample_x", sample_R16S[0], 0);
    model_reset();
    #10;
    rst = 1'b1;
    idle(6);

    // Randomized boxes, pitches changed only while idle.
    for (int k = 0; k < 40; k++) begin
      int s, llx, lly, urx, ury;
      if (k % 5 == 0) begin
        drain();
        subSample_RnnnnU = pitches[$urandom_range(0, 7)];
      end
      s   = pitch_step(subSample_RnnnnU);
      llx = (int'($urandom_range(0, 64)) - 32) * 128;
      lly = (int'($urandom_range(0, 64)) - 32) * 128;
      urx = llx + int'($urandom_range(0, 4)) * s + int'($urandom_range(0, s / 128 - 1)) * 128;
      ury = lly + int'($urandom_range(0, 4)) * s + int'($urandom_range(0, s / 128 - 1)) * 128;
      if ($urandom_range(0, 9) == 0) urx = llx - 128;
      if ($urandom_range(0, 9) == 0) ury = lly - 128;
      present(llx, lly, urx, ury, n);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
